// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared types, widths and reset constant for the instruction prefetch queue
package ifetch_queue_pkg;
  localparam int CFG_CPU_ADDR_BITS = 48;
  localparam int CNT_W = 8;
  localparam logic [63:0] RESET_VECTOR_DEFAULT = 64'h10000;
  typedef struct packed {
    logic [CFG_CPU_ADDR_BITS-1:0] pc;
    logic [63:0] data;
    logic load_fault;
  } ifetch_entry_type;
  typedef struct packed {
    logic [CFG_CPU_ADDR_BITS-1:0] fetch_pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] discard_cnt;
    logic halted;
  } ifetch_queue_registers;
  localparam ifetch_queue_registers ifetch_queue_r_reset = '{
    fetch_pc: RESET_VECTOR_DEFAULT[CFG_CPU_ADDR_BITS-1:0],
    inflight: '0,
    discard_cnt: '0,
    halted: 1'b0
  };
endpackage

// File: rtl/ifetch_queue_fifo.sv
// ifetch_fifo: synchronous FIFO of fetch packets with flush and same-cycle push/pop
module ifetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int depth_log2 = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_push,
  input  ifetch_entry_type     i_wdata,
  input  logic                 i_pop,
  output ifetch_entry_type     o_head,
  output logic [depth_log2:0]  o_count,
  output logic                 o_empty
);
  localparam int CW = depth_log2 + 1;
  ifetch_entry_type mem [2**depth_log2];
  logic [depth_log2-1:0] wr, rd;
  logic do_pop;
  assign o_empty = o_count == '0;
  assign do_pop = i_pop && !o_empty;
  assign o_head = mem[rd];
  always_ff @(posedge i_clk)
    if (i_push) mem[wr] <= i_wdata;
  always_ff @(posedge i_clk)
    if (i_rst || i_flush) begin
      wr <= '0;
      rd <= '0;
      o_count <= '0;
    end else begin
      wr <= wr + depth_log2'(i_push);
      rd <= rd + depth_log2'(do_pop);
      o_count <= o_count + CW'(i_push) - CW'(do_pop);
    end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: sequential instruction prefetch with redirect flush and fault halt; define IFETCH_QUEUE_BYPASS_EN for empty-FIFO zero-latency bypass
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int depth_log2 = 2,
  parameter logic [63:0] reset_vector = 64'h10000
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_redirect_valid,
  input  logic [CFG_CPU_ADDR_BITS-1:0]  i_redirect_pc,
  output logic                          o_req_valid,
  output logic [CFG_CPU_ADDR_BITS-1:0]  o_req_addr,
  input  logic                          i_req_ready,
  input  logic                          i_resp_valid,
  input  logic [CFG_CPU_ADDR_BITS-1:0]  i_resp_addr,
  input  logic [63:0]                   i_resp_data,
  input  logic                          i_resp_load_fault,
  output logic                          o_resp_ready,
  output logic                          o_instr_valid,
  output logic [CFG_CPU_ADDR_BITS-1:0]  o_instr_pc,
  output logic [63:0]                   o_instr_data,
  output logic                          o_instr_load_fault,
  input  logic                          i_instr_ready
);
  localparam int A = CFG_CPU_ADDR_BITS;
  ifetch_queue_registers r, rin;
  ifetch_entry_type head, resp_e, out_e;
  logic [depth_log2:0] cnt;
  logic [CNT_W-1:0] inflight_next;
  logic empty, fire, keep, flt, byp, push, pop;
  assign resp_e = '{pc: i_resp_addr, data: i_resp_data, load_fault: i_resp_load_fault};
  assign o_req_valid = !i_rst && !r.halted && !i_redirect_valid && (int'(cnt) + int'(r.inflight) < (1 << depth_log2));
  assign o_req_addr = r.fetch_pc;
  assign o_resp_ready = 1'b1;
  assign fire = o_req_valid && i_req_ready;
  assign keep = !i_rst && i_resp_valid && r.discard_cnt == '0 && !i_redirect_valid;
  assign flt = keep && i_resp_load_fault;
  assign inflight_next = r.inflight + CNT_W'(fire) - CNT_W'(i_resp_valid);
`ifdef IFETCH_QUEUE_BYPASS_EN
  assign byp = empty && keep;
`else
  assign byp = 1'b0;
`endif
  assign push = keep && !(byp && i_instr_ready);
  assign pop = !empty && i_instr_ready;
  assign out_e = byp ? resp_e : head;
  assign o_instr_valid = !empty || byp;
  assign o_instr_pc = o_instr_valid ? out_e.pc : '0;
  assign o_instr_data = o_instr_valid ? out_e.data : '0;
  assign o_instr_load_fault = o_instr_valid && out_e.load_fault;
  always_comb begin
    rin.fetch_pc = i_redirect_valid ? {i_redirect_pc[A-1:2], 2'b00} : fire ? r.fetch_pc + A'(8) : r.fetch_pc;
    rin.inflight = inflight_next;
    rin.halted = !i_redirect_valid && (flt || r.halted);
    rin.discard_cnt = (i_redirect_valid || flt) ? inflight_next :
                      (i_resp_valid && r.discard_cnt != '0) ? r.discard_cnt - CNT_W'(1) : r.discard_cnt;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r <= ifetch_queue_r_reset;
      r.fetch_pc <= reset_vector[A-1:0];
    end else
      r <= rin;
  ifetch_fifo #(.depth_log2(depth_log2)) u_fifo (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_flush(i_redirect_valid),
    .i_push(push),
    .i_wdata(resp_e),
    .i_pop(pop),
    .o_head(head),
    .o_count(cnt),
    .o_empty(empty)
  );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized icache/decode environment checked against a queue-based reference model
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;
  localparam int A = CFG_CPU_ADDR_BITS;
  localparam int DEPTH = 4;
`ifdef IFETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic i_clk = 1'b0, i_rst = 1'b1;
  logic i_redirect_valid = 1'b0, i_req_ready = 1'b0, i_resp_valid = 1'b0;
  logic i_resp_load_fault = 1'b0, i_instr_ready = 1'b0;
  logic [A-1:0] i_redirect_pc = '0, i_resp_addr = '0;
  logic [63:0] i_resp_data = '0;
  logic o_req_valid, o_resp_ready, o_instr_valid, o_instr_load_fault;
  logic [A-1:0] o_req_addr, o_instr_pc;
  logic [63:0] o_instr_data;

  ifetch_queue dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_redirect_valid(i_redirect_valid), .i_redirect_pc(i_redirect_pc),
    .o_req_valid(o_req_valid), .o_req_addr(o_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_addr(i_resp_addr), .i_resp_data(i_resp_data),
    .i_resp_load_fault(i_resp_load_fault), .o_resp_ready(o_resp_ready),
    .o_instr_valid(o_instr_valid), .o_instr_pc(o_instr_pc), .o_instr_data(o_instr_data),
    .o_instr_load_fault(o_instr_load_fault), .i_instr_ready(i_instr_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [A-1:0] addr; logic [63:0] data; logic stale; } pend_t;
  typedef struct { logic [A-1:0] pc; logic [63:0] data; logic fault; } pkt_t;
  pend_t pend[$];
  pkt_t fifo[$];
  logic [A-1:0] m_pc;
  logic m_halted;
  logic [A-1:0] fault_addr = '1;
  int n_vec = 0, n_err = 0, n_req = 0;
  int ready_pct = 100, resp_pct = 100, take_pct = 100, fault_pct = 0;

  task automatic model_reset();
    pend.delete();
    fifo.delete();
    m_pc = 48'h10000;
    m_halted = 1'b0;
  endtask

  task automatic drive_cycle(input logic redir, input logic [A-1:0] rpc, input logic force_resp);
    pkt_t exp;
    pend_t r;
    logic m_rv, m_keep, exp_v, byp;
    @(negedge i_clk);
    i_redirect_valid = redir;
    i_redirect_pc = rpc;
    i_req_ready = $urandom_range(99) < ready_pct;
    i_instr_ready = $urandom_range(99) < take_pct;
    i_resp_valid = pend.size() > 0 && (force_resp || $urandom_range(99) < resp_pct);
    i_resp_addr = pend.size() > 0 ? pend[0].addr : '0;
    i_resp_data = pend.size() > 0 ? pend[0].data : '0;
    i_resp_load_fault = pend.size() > 0 && (pend[0].addr == fault_addr || $urandom_range(99) < fault_pct);
    m_rv = !m_halted && !redir && (fifo.size() + pend.size() < DEPTH);
    m_keep = 1'b0;
    if (i_resp_valid && !redir) m_keep = !pend[0].stale;
    exp_v = fifo.size() > 0;
    byp = BYP && !exp_v && m_keep;
    exp = '{pc: '0, data: '0, fault: 1'b0};
    if (exp_v) exp = fifo[0];
    if (byp) begin
      exp_v = 1'b1;
      exp = '{pc: i_resp_addr, data: i_resp_data, fault: i_resp_load_fault};
    end
    #1;
    n_vec++;
    if (o_req_valid !== m_rv) begin
      n_err++;
      $display("FAIL req_valid t=%0t got %b want %b", $time, o_req_valid, m_rv);
    end
    if (m_rv) begin
      n_vec++;
      if (o_req_addr !== m_pc) begin
        n_err++;
        $display("FAIL req_addr t=%0t got %h want %h", $time, o_req_addr, m_pc);
      end
    end
    n_vec++;
    if (o_instr_valid !== exp_v) begin
      n_err++;
      $display("FAIL instr_valid t=%0t got %b want %b", $time, o_instr_valid, exp_v);
    end
    if (exp_v) begin
      n_vec++;
      if ({o_instr_pc, o_instr_data, o_instr_load_fault} !== {exp.pc, exp.data, exp.fault}) begin
        n_err++;
        $display("FAIL instr_pkt t=%0t got %h/%h/%b want %h/%h/%b", $time,
                 o_instr_pc, o_instr_data, o_instr_load_fault, exp.pc, exp.data, exp.fault);
      end
    end
    @(posedge i_clk);
    if (i_resp_valid) r = pend.pop_front();
    if (m_rv && i_req_ready) begin
      pend.push_back('{addr: m_pc, data: {$urandom, $urandom}, stale: 1'b0});
      m_pc = m_pc + A'(8);
      n_req++;
    end
    if (i_instr_ready && fifo.size() > 0) void'(fifo.pop_front());
    if (m_keep) begin
      if (!(byp && i_instr_ready)) fifo.push_back('{pc: i_resp_addr, data: i_resp_data, fault: i_resp_load_fault});
      if (i_resp_load_fault) begin
        m_halted = 1'b1;
        foreach (pend[k]) pend[k].stale = 1'b1;
      end
    end
    if (redir) begin
      fifo.delete();
      m_pc = {rpc[A-1:2], 2'b00};
      m_halted = 1'b0;
      foreach (pend[k]) pend[k].stale = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    {i_redirect_valid, i_req_ready, i_resp_valid, i_resp_load_fault, i_instr_ready} = '0;
    @(posedge i_clk);
    @(negedge i_clk);
    #1;
    n_vec++;
    if ({o_req_valid, o_instr_valid, o_instr_load_fault, o_resp_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_flags got rv=%b iv=%b f=%b rr=%b want 0 0 0 1", o_req_valid, o_instr_valid, o_instr_load_fault, o_resp_ready);
    end
    n_vec++;
    if (o_instr_pc !== '0 || o_instr_data !== '0) begin
      n_err++;
      $display("FAIL reset_instr got pc=%h data=%h want 0 0", o_instr_pc, o_instr_data);
    end
    model_reset();
    i_rst = 1'b0;
    #1;
    n_vec++;
    if (o_req_valid !== 1'b1 || o_req_addr !== 48'h10000) begin
      n_err++;
      $display("FAIL first_req got %b/%h want 1/10000", o_req_valid, o_req_addr);
    end
  endtask

  task automatic test_sequential();
    int r0;
    test_reset();
    {ready_pct, resp_pct, take_pct} = {32'd100, 32'd100, 32'd100};
    r0 = n_req;
    run(8);
    n_vec++;
    if (n_req - r0 != 8) begin
      n_err++;
      $display("FAIL seq_issue got %0d requests want 8", n_req - r0);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    test_reset();
    {ready_pct, resp_pct, take_pct} = {32'd100, 32'd100, 32'd0};
    r0 = n_req;
    run(10);
    n_vec++;
    if (n_req - r0 != 4 || o_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure got %0d requests rv=%b want 4 0", n_req - r0, o_req_valid);
    end
    take_pct = 100;
    r0 = n_req;
    run(6);
    n_vec++;
    if (n_req - r0 < 1) begin
      n_err++;
      $display("FAIL resume got %0d requests want >0", n_req - r0);
    end
  endtask

  task automatic test_redirect();
    test_reset();
    {ready_pct, resp_pct, take_pct} = {32'd100, 32'd0,32'd0};
    run(2);
    drive_cycle(1'b1, 48'h80000006, 1'b0);
    #1;
    i_redirect_valid = 1'b0;
    #1;
    n_vec++;
    if (o_instr_valid !== 1'b0 || o_req_valid !== 1'b1 || o_req_addr !== 48'h80000004) begin
      n_err++;
      $display("FAIL redirect_next got iv=%b rv=%b addr=%h want 0 1 80000004", o_instr_valid, o_req_valid, o_req_addr);
    end
    {resp_pct, take_pct} = {32'd100, 32'd100};
    run(10);
  endtask

  task automatic test_fault();
    int r0;
    test_reset();
    {ready_pct, resp_pct, take_pct} = {32'd100, 32'd100, 32'd100};
    fault_addr = 48'h10008;
    r0 = n_req;
    run(12);
    n_vec++;
    if (n_req - r0 != 3 || o_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL fault_halt got %0d requests rv=%b want 3 0", n_req - r0, o_req_valid);
    end
    fault_addr = '1;
    drive_cycle(1'b1, 48'h20000, 1'b0);
    r0 = n_req;
    run(6);
    n_vec++;
    if (n_req - r0 != 6) begin
      n_err++;
      $display("FAIL fault_resume got %0d requests want 6", n_req - r0);
    end
  endtask

  task automatic test_redirect_resp();
    int r0;
    test_reset();
    {ready_pct, resp_pct, take_pct} = {32'd100, 32'd0, 32'd0};
    run(2);
    drive_cycle(1'b1, 48'h30000, 1'b1);
    resp_pct = 100;
    r0 = n_req;
    run(10);
    n_vec++;
    if (n_req - r0 != 4) begin
      n_err++;
      $display("FAIL redir_resp_credit got %0d requests want 4", n_req - r0);
    end
  endtask

  task automatic test_wrap();
    test_reset();
    {ready_pct, resp_pct, take_pct} = {32'd100, 32'd100, 32'd100};
    drive_cycle(1'b1, 48'hFFFF_FFFF_FFF6, 1'b0);
    run(8);
  endtask

  task automatic test_random();
    test_reset();
    fault_pct = 2;
    for (int i = 0; i < 3000; i++) begin
      if (i % 100 == 0) begin
        ready_pct = $urandom_range(100, 20);
        resp_pct = $urandom_range(100, 20);
        take_pct = $urandom_range(100, 10);
      end
      if (i % 1000 == 999) test_reset();
      else if ($urandom_range(99) < 3) drive_cycle(1'b1, A'({$urandom, $urandom}), $urandom_range(1));
      else drive_cycle(1'b0, '0, 1'b0);
    end
    fault_pct = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_fault();
    test_redirect_resp();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
